imm_extend_pipe: RTL and testbench

- Parametrised, registered immediate-extension unit for the datapath.
- Accepts an IN_W-bit immediate plus a 2-bit mode and extends it to OUT_W bits using one of four modes:
  - zero extension
  - sign extension
  - upper placement (lui)
  - sign extension then shift left (branch/jump offset)
- Results sit in a 2-entry buffer with valid/ready handshakes on both sides, so the unit can be placed between decode and execute in a pipelined core.
- Each result carries a sideband tag and an overflow flag.

---
 rtl/imm_extend_pipe.sv | 123 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension unit: extends an IN_W-bit immediate to OUT_W bits
// in one of four modes and buffers results in a 2-entry FIFO with valid/ready on both sides.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic [1:0]       dbgCount
);

    localparam int WIDE_W = OUT_W + SHIFT;
    localparam int PAD_W  = OUT_W - IN_W;

    generate
        if (IN_W < 2 || OUT_W < IN_W || SHIFT < 0 || SHIFT >= OUT_W) begin : gBadParams
            $error("imm_extend_pipe: illegal IN_W/OUT_W/SHIFT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_SIGN  = 2'd1,
        MODE_UPPER = 2'd2,
        MODE_SHOFF = 2'd3
    } mode_e;

    logic [OUT_W-1:0]  dataMem [2];
    logic [TAG_W-1:0]  tagMem  [2];
    logic              ovfMem  [2];
    logic              wrPtr;
    logic              rdPtr;
    logic [1:0]        count;

    logic [WIDE_W-1:0] wideVal;
    logic [OUT_W-1:0]  extVal;
    logic              extOvf;
    logic              push;
    logic              pop;

    // The extended value is computed at push time and stored, so the head entry
    // never depends on the current input.
    always_comb begin
        wideVal = WIDE_W'($signed(in_imm)) << SHIFT;
        extVal  = '0;
        extOvf  = 1'b0;
        unique case (mode_e'(in_mode))
            MODE_ZERO:  extVal = OUT_W'(in_imm);
            MODE_SIGN:  extVal = OUT_W'($signed(in_imm));
            MODE_UPPER: extVal = OUT_W'(in_imm) << PAD_W;
            MODE_SHOFF: begin
                extVal = wideVal[OUT_W-1:0];
                // Lossless only if re-sign-extending the kept bits rebuilds the wide value.
                extOvf = (WIDE_W'($signed(extVal)) != wideVal);
            end
            default: extVal = '0;
        endcase
    end

    // Handshake: a side transfers on the edge where valid and ready are both high;
    // in_ready depends only on the registered count and flush, never on out_ready,
    // and a flush cycle neither accepts nor retires anything.
    assign in_ready  = (count != 2'd2) && !flush;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign dbgCount  = count;

    assign out_data = out_valid ? dataMem[rdPtr] : '0;
    assign out_tag  = out_valid ? tagMem[rdPtr]  : '0;
    assign out_ovf  = out_valid ? ovfMem[rdPtr]  : 1'b0;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count <= 2'd0;
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dataMem[i] <= '0;
                tagMem[i]  <= '0;
                ovfMem[i]  <= 1'b0;
            end
        end else if (flush) begin
            count <= 2'd0;
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dataMem[i] <= '0;
                tagMem[i]  <= '0;
                ovfMem[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                dataMem[wrPtr] <= extVal;
                tagMem[wrPtr]  <= in_tag;
                ovfMem[wrPtr]  <= extOvf;
                wrPtr          <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed cases plus random traffic against an arithmetic
// reference model, with a negedge monitor popping an expected-result queue.
module tb_imm_extend_pipe;

    logic        CLK;
    logic        Reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_ovf;
    logic [1:0]  dbgCount;

    logic        d2_flush;
    logic        d2_in_valid;
    logic        d2_in_ready;
    logic [15:0] d2_in_imm;
    logic [1:0]  d2_in_mode;
    logic [4:0]  d2_in_tag;
    logic        d2_out_valid;
    logic        d2_out_ready;
    logic [15:0] d2_out_data;
    logic [4:0]  d2_out_tag;
    logic        d2_out_ovf;
    logic [1:0]  d2_dbgCount;

    int checks = 0;
    int errors = 0;
    logic [37:0] exp_q[$];
    bit rnd_ready = 0;

    imm_extend_pipe dut (
        .CLK(CLK), .Reset(Reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_ovf(out_ovf), .dbgCount(dbgCount)
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(2), .TAG_W(5)) dut16 (
        .CLK(CLK), .Reset(Reset), .flush(d2_flush),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_imm(d2_in_imm),
        .in_mode(d2_in_mode), .in_tag(d2_in_tag),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
        .out_tag(d2_out_tag), .out_ovf(d2_out_ovf), .dbgCount(d2_dbgCount)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain signed/unsigned arithmetic on the immediate's value.
    function automatic void model(input int in_w, input int out_w, input int shift,
                                  input longint unsigned imm, input logic [1:0] mode,
                                  output longint unsigned data, output logic ovf);
        longint sval;
        longint r;
        longint lim;
        longint unsigned mask;
        mask = (64'd1 << out_w) - 64'd1;
        sval = imm[in_w-1] ? (longint'(imm) - (longint'(1) << in_w)) : longint'(imm);
        lim  = longint'(1) << (out_w - 1);
        ovf  = 1'b0;
        case (mode)
            2'd0: r = longint'(imm);
            2'd1: r = sval;
            2'd2: r = longint'(imm) * (longint'(1) << (out_w - in_w));
            default: begin
                r   = sval * (longint'(1) << shift);
                ovf = (r < -lim) || (r >= lim);
            end
        endcase
        data = $unsigned(r) & mask;
    endfunction

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // driver: hold the item until accepted, then record its expected result
    task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        longint unsigned d;
        logic o;
        bit done;
        done = 0;
        model(16, 32, 2, 64'(imm), mode, d, o);
        in_imm = imm;
        in_mode = mode;
        in_tag = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            if (in_ready) done = 1;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        if (done) exp_q.push_back({32'(d), tag, o});
        check("accept", 64'(done), 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge CLK);
            #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge CLK);
        #1;
        check("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic send16(input logic [15:0] imm, input logic [15:0] exp_d, input logic exp_o);
        d2_in_imm = imm;
        d2_in_mode = 2'd3;
        d2_in_tag = imm[4:0];
        d2_in_valid = 1'b1;
        @(negedge CLK);
        check("w16_in_ready", 64'(d2_in_ready), 64'd1);
        @(posedge CLK);
        #1;
        d2_in_valid = 1'b0;
        check("w16_out_valid", 64'(d2_out_valid), 64'd1);
        check("w16_data", 64'(d2_out_data), 64'(exp_d));
        check("w16_ovf", 64'(d2_out_ovf), 64'(exp_o));
    endtask

    initial begin
        logic [37:0] e;
        logic [15:0] imm;
        Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0;
        out_ready = 1'b0;
        d2_flush = 1'b0; d2_in_valid = 1'b0; d2_in_imm = '0; d2_in_mode = '0; d2_in_tag = '0;
        d2_out_ready = 1'b1;

        // scoreboard monitor and random backpressure
        fork
            forever begin
                @(negedge CLK);
                if (!Reset && !flush && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data=%h tag=%h ovf=%b, required no output",
                                 out_data, out_tag, out_ovf);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", 64'(out_data), 64'(e[37:6]));
                        check("sb_tag", 64'(out_tag), 64'(e[5:1]));
                        check("sb_ovf", 64'(out_ovf), 64'(e[0]));
                    end
                end
            end
            forever begin
                @(posedge CLK);
                #1;
                if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            end
        join_none

        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(dbgCount), 64'd0);

        // mode sweep, back to back, 1-cycle latency
        out_ready = 1'b1;
        send(16'h8001, 2'd0, 5'd1);
        check("zero_valid", 64'(out_valid), 64'd1);
        check("zero_data", 64'(out_data), 64'h0000_8001);
        send(16'h8001, 2'd1, 5'd2);
        check("sign_data", 64'(out_data), 64'hFFFF_8001);
        send(16'h1234, 2'd2, 5'd3);
        check("upper_data", 64'(out_data), 64'h1234_0000);
        send(16'hFFFF, 2'd3, 5'd4);
        check("shoff_data", 64'(out_data), 64'hFFFF_FFFC);
        check("shoff_ovf", 64'(out_ovf), 64'd0);
        drain();

        // backpressure: third item held upstream
        out_ready = 1'b0;
        send(16'h0011, 2'd1, 5'd1);
        send(16'h0022, 2'd1, 5'd2);
        check("bp_count", 64'(dbgCount), 64'd2);
        in_imm = 16'h0033; in_mode = 2'd1; in_tag = 5'd3; in_valid = 1'b1;
        @(negedge CLK);
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        @(posedge CLK);
        #1;
        check("bp_head_held", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        send(16'h0033, 2'd1, 5'd3);
        drain();

        // simultaneous push/pop at count=1
        out_ready = 1'b0;
        send(16'($urandom), 2'($urandom_range(0, 3)), 5'd10);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom), 2'($urandom_range(0, 3)), 5'(11 + i));
            check("pp_count", 64'(dbgCount), 64'd1);
            check("pp_head_tag", 64'(out_tag), 64'(11 + i));
        end
        drain();

        // flush with two buffered entries and an input offered
        out_ready = 1'b0;
        send(16'h0A0A, 2'd0, 5'd5);
        send(16'h0B0B, 2'd0, 5'd6);
        in_imm = 16'h0C0C; in_mode = 2'd0; in_tag = 5'd31; in_valid = 1'b1; flush = 1'b1;
        @(negedge CLK);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge CLK);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_count", 64'(dbgCount), 64'd0);
        check("flush_out_data", 64'(out_data), 64'd0);
        drain();

        // asynchronous reset with two entries held
        out_ready = 1'b0;
        send(16'h8000, 2'd3, 5'd7);
        send(16'h7FFF, 2'd3, 5'd8);
        @(posedge CLK);
        #3;
        Reset = 1'b1;
        #1;
        exp_q.delete();
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_out_ovf", 64'(out_ovf), 64'd0);
        check("arst_out_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_count", 64'(dbgCount), 64'd0);

        // OUT_W == IN_W overflow cases
        send16(16'h4000, 16'h0000, 1'b1);
        send16(16'hE000, 16'h8000, 1'b0);
        send16(16'h1FFF, 16'h7FFC, 1'b0);

        // random traffic with random backpressure
        rnd_ready = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: imm = 16'h0000;
                1: imm = 16'h7FFF;
                2: imm = 16'h8000;
                3: imm = 16'hFFFF;
                default: imm = 16'($urandom);
            endcase
            send(imm, 2'($urandom_range(0, 3)), 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        rnd_ready = 0;
        @(posedge CLK);
        #1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
